// File: rtl/ecc_25_rd_pipe.sv
// Read-side SECDED check stage: two-stage valid/ready pipe around ecc_25_cal,
// with saturating SBE/DBE counters and a sticky first-DBE syndrome capture.

module ecc_25_cal (
  input  logic [24:0] data_in,
  input  logic [5:0]  parity_in,
  output logic [24:0] data_out,
  output logic [5:0]  parity_out,
  output logic        sbit_err,
  output logic        dbit_err
);
  localparam int unsigned DATA_WIDTH   = 25;
  localparam int unsigned PARITY_WIDTH = 6;

  // Hamming position of data bit k: the k-th non-power-of-two index from 3 upward.
  function automatic logic [4:0] data_pos(input int unsigned k);
    int unsigned cnt;
    data_pos = '0;
    cnt      = 0;
    for (int unsigned p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) data_pos = 5'(p);
        cnt++;
      end
    end
  endfunction

  logic [4:0]              hp;
  logic [4:0]              pos;
  logic [PARITY_WIDTH-1:0] syn;
  logic                    hit;

  // Bit 5 is overall parity over data and Hamming bits, so every column has odd weight.
  always_comb begin
    hp         = '0;
    pos        = '0;
    hit        = 1'b0;
    data_out   = data_in;
    sbit_err   = 1'b0;
    dbit_err   = 1'b0;
    for (int k = 0; k < int'(DATA_WIDTH); k++) begin
      if (data_in[k]) hp = hp ^ data_pos(32'(k));
    end
    parity_out = {(^data_in) ^ (^hp), hp};
    syn        = parity_in ^ parity_out;
    if (syn != '0) begin
      if (^syn) begin
        if ($onehot(syn)) begin
          sbit_err = 1'b1;
        end else begin
          for (int k = 0; k < int'(DATA_WIDTH); k++) begin
            pos = data_pos(32'(k));
            if (syn == {~^pos, pos}) begin
              data_out[k] = ~data_in[k];
              hit         = 1'b1;
            end
          end
          sbit_err = hit;
          dbit_err = ~hit;
        end
      end else begin
        dbit_err = 1'b1;
      end
    end
  end
endmodule

module ecc_25_rd_pipe #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [30:0]          in_word,
  input  logic                 bypass,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [24:0]          out_data,
  output logic                 out_sbe,
  output logic                 out_dbe,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] sbe_cnt,
  output logic [CNT_WIDTH-1:0] dbe_cnt,
  output logic                 dbe_flag,
  output logic [5:0]           dbe_syn
);
  localparam int unsigned DATA_WIDTH   = 25;
  localparam int unsigned PARITY_WIDTH = 6;

  logic                    s1_vld_q;
  logic [30:0]             s1_word_q;
  logic                    out_vld_q, out_sbe_q, out_dbe_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CNT_WIDTH-1:0]    sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
  logic                    dbe_flag_q, dbe_flag_d;
  logic [PARITY_WIDTH-1:0] dbe_syn_q, dbe_syn_d;

  logic [DATA_WIDTH-1:0]   dec_data;
  logic [PARITY_WIDTH-1:0] dec_parity, syndrome;
  logic                    dec_sbe, dec_dbe;
  logic                    adv1, adv2, xfer, sbe_ev, dbe_ev;

  ecc_25_cal u_cal (
    .data_in    (s1_word_q[24:0]),
    .parity_in  (s1_word_q[30:25]),
    .data_out   (dec_data),
    .parity_out (dec_parity),
    .sbit_err   (dec_sbe),
    .dbit_err   (dec_dbe)
  );

  assign syndrome = s1_word_q[30:25] ^ dec_parity;

  // Pipeline enables and status next-state; events count at S1->S2 transfer.
  always_comb begin
    adv2       = ~out_vld_q | out_rdy;
    adv1       = ~s1_vld_q | adv2;
    xfer       = adv2 & s1_vld_q;
    sbe_ev     = xfer & ~bypass & dec_sbe;
    dbe_ev     = xfer & ~bypass & dec_dbe;
    sbe_cnt_d  = sbe_cnt_q;
    dbe_cnt_d  = dbe_cnt_q;
    dbe_flag_d = dbe_flag_q;
    dbe_syn_d  = dbe_syn_q;
    if (cnt_clr) begin
      sbe_cnt_d  = CNT_WIDTH'(sbe_ev);
      dbe_cnt_d  = CNT_WIDTH'(dbe_ev);
      dbe_flag_d = dbe_ev;
      dbe_syn_d  = dbe_ev ? syndrome : '0;
    end else begin
      if (sbe_ev && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + CNT_WIDTH'(1);
      if (dbe_ev && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + CNT_WIDTH'(1);
      if (dbe_ev && !dbe_flag_q) begin
        dbe_flag_d = 1'b1;
        dbe_syn_d  = syndrome;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_word_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sbe_q  <= 1'b0;
      out_dbe_q  <= 1'b0;
      sbe_cnt_q  <= '0;
      dbe_cnt_q  <= '0;
      dbe_flag_q <= 1'b0;
      dbe_syn_q  <= '0;
    end else begin
      if (adv1) begin
        s1_vld_q <= in_vld;
        if (in_vld) s1_word_q <= in_word;
      end
      if (adv2) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_data_q <= bypass ? s1_word_q[24:0] : dec_data;
          out_sbe_q  <= dec_sbe & ~bypass;
          out_dbe_q  <= dec_dbe & ~bypass;
        end
      end
      sbe_cnt_q  <= sbe_cnt_d;
      dbe_cnt_q  <= dbe_cnt_d;
      dbe_flag_q <= dbe_flag_d;
      dbe_syn_q  <= dbe_syn_d;
    end
  end

  assign in_rdy   = adv1;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_sbe  = out_sbe_q;
  assign out_dbe  = out_dbe_q;
  assign sbe_cnt  = sbe_cnt_q;
  assign dbe_cnt  = dbe_cnt_q;
  assign dbe_flag = dbe_flag_q;
  assign dbe_syn  = dbe_syn_q;
endmodule

// File: tb/tb_ecc_25_rd_pipe.sv
// Scoreboard bench for ecc_25_rd_pipe: directed ECC vectors, random error
// injection, backpressure, bypass, counter clear/saturation and async reset.

module tb_ecc_25_rd_pipe;
  logic        clk, rst_n;
  logic        in_vld, in_rdy, bypass, out_vld, out_rdy, out_sbe, out_dbe, cnt_clr, dbe_flag;
  logic [30:0] in_word;
  logic [24:0] out_data;
  logic [15:0] sbe_cnt, dbe_cnt;
  logic [5:0]  dbe_syn;

  ecc_25_rd_pipe #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_word(in_word),
    .bypass(bypass), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_sbe(out_sbe), .out_dbe(out_dbe), .cnt_clr(cnt_clr), .sbe_cnt(sbe_cnt),
    .dbe_cnt(dbe_cnt), .dbe_flag(dbe_flag), .dbe_syn(dbe_syn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] d;
    logic        s;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_sbe, m_dbe;
  logic        m_flag;
  logic [5:0]  m_syn;
  logic        hold_pend;
  logic [26:0] hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: walk Hamming positions 3..30 skipping powers of two.
  function automatic logic [5:0] enc(input logic [24:0] d);
    logic [4:0] h;
    int         p;
    h = '0;
    p = 3;
    for (int k = 0; k < 25; k++) begin
      while ((p & (p - 1)) == 0) p++;
      if (d[k]) h = h ^ 5'(p);
      p++;
    end
    return {(^d) ^ (^h), h};
  endfunction

  task automatic send(input logic [30:0] w, input logic byp, input logic [24:0] ed,
                      input logic es, input logic ee);
    int   g;
    exp_t x;
    in_word = w;
    bypass  = byp;
    in_vld  = 1'b1;
    g = 0;
    while (!in_rdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("in_rdy_timeout", 32'(in_rdy), 32'd1);
    x.d = ed;
    x.s = es & ~byp;
    x.e = ee & ~byp;
    sb.push_back(x);
    if (!byp) begin
      if (es && m_sbe != 16'hFFFF) m_sbe = m_sbe + 16'd1;
      if (ee && m_dbe != 16'hFFFF) m_dbe = m_dbe + 16'd1;
      if (ee && !m_flag) begin
        m_flag = 1'b1;
        m_syn  = w[30:25] ^ enc(w[24:0]);
      end
    end
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_vld) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_sbe_cnt"}, 32'(sbe_cnt), 32'(m_sbe));
    chk({tag, "_dbe_cnt"}, 32'(dbe_cnt), 32'(m_dbe));
    chk({tag, "_dbe_flag"}, 32'(dbe_flag), 32'(m_flag));
    chk({tag, "_dbe_syn"}, 32'(dbe_syn), 32'(m_syn));
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #2 out_rdy = v;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // Output monitor: compares every downstream handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (hold_pend && out_vld) chk("stall_hold", 32'({out_data, out_sbe, out_dbe}), 32'(hold_val));
      hold_pend = out_vld && !out_rdy;
      hold_val  = {out_data, out_sbe, out_dbe};
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_vld", 32'(out_vld), 32'd0);
        end else begin
          x = sb.pop_front();
          chk("word", 32'({out_data, out_sbe, out_dbe}), 32'(x));
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] cw;
    logic [24:0] d;
    int          ty, i, j;
    in_vld = 1'b0; in_word = '0; bypass = 1'b0; out_rdy = 1'b1; cnt_clr = 1'b0;
    m_sbe = '0; m_dbe = '0; m_flag = 1'b0; m_syn = '0; hold_pend = 1'b0; hold_val = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out", 32'({out_data, out_sbe, out_dbe}), 32'd0);
    chk_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean zero word and two-cycle latency.
    send(31'h0, 1'b0, 25'h0, 1'b0, 1'b0);
    chk("lat_cycle1", 32'(out_vld), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_vld), 32'd1);
    drain();
    chk_cnt("clean");

    // Directed vectors.
    send({6'b000000, 25'h0000001}, 1'b0, 25'h0, 1'b1, 1'b0);
    drain();
    chk("sbe_cnt_1", 32'(sbe_cnt), 32'd1);
    send({6'b000000, 25'h0000003}, 1'b0, 25'h0000003, 1'b0, 1'b1);
    drain();
    chk("dbe_syn_dir", 32'(dbe_syn), 32'h06);
    chk_cnt("dbe_dir");
    send({6'b000001, 25'h0000000}, 1'b0, 25'h0, 1'b1, 1'b0);
    drain();
    chk_cnt("par_sbe");

    // Bypass: raw data, no flags, no counting.
    send({6'b000000, 25'h0000001}, 1'b1, 25'h0000001, 1'b0, 1'b0);
    send({6'b000000, 25'h0000003}, 1'b1, 25'h0000003, 1'b0, 1'b0);
    send({6'b000001, 25'h0000000}, 1'b1, 25'h0000000, 1'b0, 1'b0);
    drain();
    chk_cnt("bypass");

    // Random error injection, back-to-back.
    for (int n = 0; n < 40; n++) begin
      d  = 25'($urandom);
      cw = {enc(d), d};
      ty = $urandom_range(0, 3);
      if (ty == 0) begin
        send(cw, 1'b0, d, 1'b0, 1'b0);
      end else if (ty == 1) begin
        i = $urandom_range(0, 24);
        cw[i] = ~cw[i];
        send(cw, 1'b0, d, 1'b1, 1'b0);
      end else if (ty == 2) begin
        i = $urandom_range(25, 30);
        cw[i] = ~cw[i];
        send(cw, 1'b0, d, 1'b1, 1'b0);
      end else begin
        i = $urandom_range(0, 30);
        j = (i + $urandom_range(1, 30)) % 31;
        cw[i] = ~cw[i];
        cw[j] = ~cw[j];
        send(cw, 1'b0, cw[24:0], 1'b0, 1'b1);
      end
    end
    drain();
    chk("dbe_syn_sticky", 32'(dbe_syn), 32'h06);
    chk_cnt("random");

    // Backpressure: out_rdy low for three edges while four words stream in.
    fork
      begin
        for (int n = 0; n < 4; n++) begin
          d = 25'h0ABCDE + 25'(n * 25'h111);
          send({enc(d), d}, 1'b0, d, 1'b0, 1'b0);
        end
      end
      begin
        @(posedge clk);
        #2 out_rdy = 1'b0;
        @(negedge clk);
        chk("bp_in_rdy_1word", 32'(in_rdy), 32'd1);
        @(negedge clk);
        chk("bp_in_rdy_full", 32'(in_rdy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 out_rdy = 1'b1;
      end
    join
    drain();

    // cnt_clr coinciding with an SBE, then with a DBE.
    send({6'b000000, 25'h0000001}, 1'b0, 25'h0, 1'b1, 1'b0);
    pulse_clr();
    drain();
    m_sbe = 16'd1; m_dbe = '0; m_flag = 1'b0; m_syn = '0;
    chk_cnt("clr_sbe");
    send({6'b000000, 25'h0000005}, 1'b0, 25'h0000005, 1'b0, 1'b1);
    drain();
    send({6'b000000, 25'h0000003}, 1'b0, 25'h0000003, 1'b0, 1'b1);
    pulse_clr();
    drain();
    m_sbe = '0; m_dbe = 16'd1; m_flag = 1'b1; m_syn = 6'b000110;
    chk_cnt("clr_dbe");

    // Asynchronous reset with words in flight.
    set_rdy(1'b0);
    send({enc(25'h1234), 25'h1234}, 1'b0, 25'h1234, 1'b0, 1'b0);
    send({enc(25'h5678), 25'h5678}, 1'b0, 25'h5678, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_out", 32'({out_data, out_sbe, out_dbe}), 32'd0);
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);
    sb.delete();
    m_sbe = '0; m_dbe = '0; m_flag = 1'b0; m_syn = '0;
    chk_cnt("arst");
    @(negedge clk);
    rst_n = 1'b1;
    set_rdy(1'b1);
    drain();

    // Saturation of the SBE counter.
    for (int n = 0; n < 65535; n++) send({6'b000000, 25'h0000001}, 1'b0, 25'h0, 1'b1, 1'b0);
    drain();
    chk("sat_reach", 32'(sbe_cnt), 32'h0000FFFF);
    send({6'b000000, 25'h0000001}, 1'b0, 25'h0, 1'b1, 1'b0);
    send({6'b000000, 25'h0000001}, 1'b0, 25'h0, 1'b1, 1'b0);
    drain();
    chk("sat_hold", 32'(sbe_cnt), 32'h0000FFFF);
    chk_cnt("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
